// File: rtl/fifo_stream_reader_pkg.sv
// Shared types and helpers for the FIFO stream reader.
package fifo_stream_reader_pkg;

    localparam int DATA_W_DEFAULT = 8;
    localparam int CNT_W_DEFAULT  = 16;

    // Depth of the output buffer; also the number of words that may be
    // committed (buffered or in flight) at any time.
    localparam logic [1:0] BUF_DEPTH = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    // A new pop is allowed only if the words already committed to the
    // buffer, minus the one leaving this cycle, leave room for it.
    // pop is only ever high while occ is non-zero, so the sum cannot underflow.
    function automatic logic credit_ok(input logic [1:0] occ,
                                       input logic       infl,
                                       input logic       pop);
        logic [2:0] committed;
        committed = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
        return (committed < {1'b0, BUF_DEPTH});
    endfunction

endpackage

// File: rtl/fifo_stream_reader_if.sv
// FIFO read port plus downstream valid/ready stream, seen from the reader.
interface fifo_stream_reader_if #(
    parameter int DATA_W = 8
);
    logic              fifo_empty;
    logic              fifo_r_en;
    logic [DATA_W-1:0] fifo_data_out;
    logic              m_valid;
    logic              m_ready;
    logic [DATA_W-1:0] m_data;

    // The reader pops the FIFO and drives the stream.
    modport master (
        input  fifo_empty,
        input  fifo_data_out,
        input  m_ready,
        output fifo_r_en,
        output m_valid,
        output m_data
    );

    // FIFO and consumer side.
    modport slave (
        output fifo_empty,
        output fifo_data_out,
        output m_ready,
        input  fifo_r_en,
        input  m_valid,
        input  m_data
    );
endinterface

// File: rtl/fifo_stream_reader_buf2.sv
// Two-entry valid/ready holding buffer; head entry is always the output.
module stream_buf2
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_en,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              rd_en,
    output logic [DATA_W-1:0] rd_data,
    output logic [1:0]        occ
);

    logic [DATA_W-1:0] head_r;
    logic [DATA_W-1:0] tail_r;
    logic [1:0]        occ_r;
    logic              rd_s;
    logic              wr_s;

    // A read of an empty buffer is ignored; a write into a full buffer is
    // dropped unless a read frees a slot in the same cycle.
    assign rd_s = rd_en && (occ_r != 2'd0);
    assign wr_s = wr_en && ((occ_r != BUF_DEPTH) || rd_s);

    // Entry shuffle: writes land at the tail, reads advance the tail to head.
    always_ff @(posedge clk) begin
        if (rst) begin
            head_r <= {DATA_W{1'b0}};
            tail_r <= {DATA_W{1'b0}};
            occ_r  <= 2'd0;
        end else begin
            case ({wr_s, rd_s})
                2'b10: begin
                    if (occ_r == 2'd0) begin
                        head_r <= wr_data;
                    end else begin
                        tail_r <= wr_data;
                    end
                    occ_r <= occ_r + 2'd1;
                end
                2'b01: begin
                    head_r <= tail_r;
                    occ_r  <= occ_r - 2'd1;
                end
                2'b11: begin
                    if (occ_r == 2'd1) begin
                        head_r <= wr_data;
                    end else begin
                        head_r <= tail_r;
                        tail_r <= wr_data;
                    end
                end
                default: begin
                    head_r <= head_r;
                end
            endcase
        end
    end

    assign rd_data = head_r;
    assign occ     = occ_r;

endmodule

// File: rtl/fifo_stream_reader.sv
// Read-side master for the synchronous FIFO: pops words and presents them on
// a valid/ready stream, hiding the FIFO's one-cycle read latency.
module fifo_stream_reader
    import fifo_stream_reader_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEFAULT,
    parameter int CNT_W  = CNT_W_DEFAULT
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 enable,
    fifo_stream_reader_if.master bus,
    output logic                 busy,
    output logic [CNT_W-1:0]     word_cnt
);

    state_t            state_r;
    state_t            state_s;
    logic              infl_r;
    logic [CNT_W-1:0]  word_cnt_r;
    logic [1:0]        occ_s;
    logic [DATA_W-1:0] head_s;
    logic              pop_s;
    logic              rd_req_s;
    logic              holding_s;

    assign pop_s     = (occ_s != 2'd0) && bus.m_ready;
    assign holding_s = (occ_s != 2'd0) || infl_r;

    // Pop request: only when enabled, data is available and a slot is free
    // for the word once it arrives.
    always_comb begin
        rd_req_s = 1'b0;
        if (enable && !bus.fifo_empty) begin
            rd_req_s = credit_ok(occ_s, infl_r, pop_s);
        end else begin
            rd_req_s = 1'b0;
        end
    end

    // The FIFO's data_out is only looked at while a read is in flight.
    stream_buf2 #(
        .DATA_W (DATA_W)
    ) u_buf (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (infl_r),
        .wr_data (bus.fifo_data_out),
        .rd_en   (pop_s),
        .rd_data (head_s),
        .occ     (occ_s)
    );

    // Remembers that the FIFO will present a word on the next cycle.
    always_ff @(posedge clk) begin
        if (rst) begin
            infl_r <= 1'b0;
        end else begin
            infl_r <= rd_req_s;
        end
    end

    // Counts words accepted downstream; wraps naturally.
    always_ff @(posedge clk) begin
        if (rst) begin
            word_cnt_r <= {CNT_W{1'b0}};
        end else if (pop_s) begin
            word_cnt_r <= word_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            word_cnt_r <= word_cnt_r;
        end
    end

    // FSM state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // FSM next state: DRAIN lets buffered and in-flight words leave after disable.
    always_comb begin
        state_s = state_r;
        case (state_r)
            ST_IDLE: begin
                if (enable) begin
                    state_s = ST_RUN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (enable) begin
                    state_s = ST_RUN;
                end else if (holding_s) begin
                    state_s = ST_DRAIN;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_DRAIN: begin
                if (enable) begin
                    state_s = ST_RUN;
                end else if (!holding_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_DRAIN;
                end
            end
            default: begin
                state_s = ST_IDLE;
            end
        endcase
    end

    assign bus.fifo_r_en = rd_req_s;
    assign bus.m_valid   = (occ_s != 2'd0);
    assign bus.m_data    = head_s;
    assign busy          = (state_r != ST_IDLE);
    assign word_cnt      = word_cnt_r;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Bench for fifo_stream_reader: behavioural FIFO, scoreboard of pushed words,
// decoupled monitor comparing every accepted word and invariant.
module tb_fifo_stream_reader;

    localparam int DATA_W = 8;
    localparam int CNT_W  = 4;
    localparam int MEM_N  = 1024;

    logic             clk;
    logic             rst;
    logic             enable;
    logic             busy;
    logic [CNT_W-1:0] word_cnt;

    fifo_stream_reader_if #(.DATA_W(DATA_W)) bus ();

    fifo_stream_reader #(
        .DATA_W (DATA_W),
        .CNT_W  (CNT_W)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .enable   (enable),
        .bus      (bus.master),
        .busy     (busy),
        .word_cnt (word_cnt)
    );

    // Reference: every pushed word is stored here in push order. The FIFO
    // pops from fifo_rd, the scoreboard expects words in order from exp_ptr.
    logic [DATA_W-1:0] mem [MEM_N];
    int unsigned wr_ptr;    // written by stimulus only
    int unsigned fifo_rd;   // written by FIFO model only
    int unsigned exp_ptr;   // written by monitor only
    int unsigned acc;       // words accepted since reset (monitor)
    int unsigned pops;      // FIFO pops since reset (monitor)
    int          total;
    int          bad;
    logic              prev_stall;
    logic [DATA_W-1:0] prev_data;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h want %0h at %0t", nm, act, req, $time);
        end
    endtask

    // Behavioural synchronous FIFO with registered data_out.
    assign bus.fifo_empty = (wr_ptr == fifo_rd);
    always @(posedge clk) begin
        if (rst) begin
            fifo_rd           <= wr_ptr;
            bus.fifo_data_out <= 8'h00;
        end else if (bus.fifo_r_en && (wr_ptr != fifo_rd)) begin
            bus.fifo_data_out <= mem[fifo_rd % MEM_N];
            fifo_rd           <= fifo_rd + 1;
        end
    end

    // Monitor: scoreboard compare plus stream/credit invariants.
    always @(negedge clk) begin
        if (rst) begin
            acc        = 0;
            pops       = 0;
            exp_ptr    = wr_ptr;
            prev_stall = 1'b0;
        end else begin
            chk("word_cnt", 32'(word_cnt), 32'(acc % 16));
            if (prev_stall) begin
                chk("hold_valid", 32'(bus.m_valid), 32'd1);
                chk("hold_data", 32'(bus.m_data), 32'(prev_data));
            end
            if (bus.fifo_r_en) begin
                pops++;
                chk("pop_not_empty", 32'(bus.fifo_empty), 32'd0);
            end
            if (bus.m_valid && bus.m_ready) begin
                if (exp_ptr == wr_ptr) begin
                    chk("unexpected_word", 32'(bus.m_data), 32'hFFFF_FFFF);
                end else begin
                    chk("data", 32'(bus.m_data), 32'(mem[exp_ptr % MEM_N]));
                    exp_ptr++;
                end
                acc++;
            end
            chk("credit", 32'((pops - acc) <= 2), 32'd1);
            prev_stall = bus.m_valid && !bus.m_ready;
            prev_data  = bus.m_data;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input logic [DATA_W-1:0] d);
        mem[wr_ptr % MEM_N] = d;
        wr_ptr++;
    endtask

    task automatic wait_drained(input string nm, input int bound);
        for (int i = 0; i < bound; i++) begin
            if ((exp_ptr == wr_ptr) && !bus.m_valid) break;
            step();
        end
        chk(nm, 32'(exp_ptr == wr_ptr), 32'd1);
    endtask

    task automatic do_reset();
        rst = 1'b1;
        step();
        rst = 1'b0;
    endtask

    initial begin
        logic [DATA_W-1:0] first_w;
        int unsigned p0;
        total = 0; bad = 0; wr_ptr = 0;
        rst = 1'b1; enable = 1'b0; bus.m_ready = 1'b0;
        step(); step();
        rst = 1'b0;

        // 1. reset with words held
        enable = 1'b1;
        push(8'h01); push(8'h02); push(8'h03);
        step(); step(); step();
        rst = 1'b1;
        step();
        chk("rst_valid", 32'(bus.m_valid), 32'd0);
        chk("rst_cnt", 32'(word_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ren", 32'(bus.fifo_r_en), 32'd0);
        rst = 1'b0;
        step();

        // 2. streaming, 1 word/clk
        bus.m_ready = 1'b1;
        push(8'h11); push(8'h22); push(8'h33); push(8'h44);
        step();
        for (int i = 0; i < 4; i++) begin
            step();
            chk("stream_valid", 32'(bus.m_valid), 32'd1);
        end
        // 5. empty boundary and re-fill latency
        step();
        chk("empty_valid", 32'(bus.m_valid), 32'd0);
        chk("stream_cnt", 32'(word_cnt), 32'd4);
        push(8'h55);
        #1;
        chk("fresh_ren", 32'(bus.fifo_r_en), 32'd1);
        step();
        chk("fresh_valid_1", 32'(bus.m_valid), 32'd0);
        step();
        chk("fresh_valid_2", 32'(bus.m_valid), 32'd1);
        chk("fresh_data", 32'(bus.m_data), 32'h55);
        wait_drained("fresh_drained", 20);

        // 3. backpressure
        bus.m_ready = 1'b0;
        first_w = 8'hA0;
        for (int i = 0; i < 6; i++) push(first_w + 8'(i));
        p0 = pops;
        for (int i = 0; i < 5; i++) step();
        chk("bp_pops", pops - p0, 32'd2);
        chk("bp_valid", 32'(bus.m_valid), 32'd1);
        chk("bp_head", 32'(bus.m_data), 32'(first_w));
        bus.m_ready = 1'b1;
        wait_drained("bp_drained", 40);

        // 4. disable with a read in flight
        for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
        step(); step();
        chk("drain_pre_ren", 32'(bus.fifo_r_en), 32'd1);
        enable = 1'b0;
        step();
        chk("drain_busy", 32'(busy), 32'd1);
        for (int i = 0; i < 10; i++) begin
            if (!busy) break;
            step();
        end
        chk("drain_idle", 32'(busy), 32'd0);
        chk("drain_delivered", 32'(fifo_rd == exp_ptr), 32'd1);
        chk("drain_fifo_kept", 32'(wr_ptr != fifo_rd), 32'd1);
        chk("drain_no_ren", 32'(bus.fifo_r_en), 32'd0);
        enable = 1'b1;
        wait_drained("drain_rest", 40);

        // 6. counter wrap
        do_reset();
        for (int i = 0; i < 17; i++) push(8'(i * 7));
        wait_drained("wrap_drained", 80);
        step();
        chk("wrap_cnt", 32'(word_cnt), 32'd1);

        // randomized traffic
        for (int c = 0; c < 400; c++) begin
            enable      = ($urandom_range(0, 9) != 0);
            bus.m_ready = ($urandom_range(0, 2) != 0);
            if ($urandom_range(0, 2) == 0) push(8'($urandom));
            step();
        end
        enable = 1'b1;
        bus.m_ready = 1'b1;
        wait_drained("rand_drained", 300);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

endmodule
